vid_pattern_gen: RTL and testbench

Free-running video timing and test-pattern source for the pixel pipeline. It generates raster counters, the `vid_sideband_if` sideband (de/sof/eol/x/y), sync pulses and a `pixel_t` pattern stream. It sits at the head of the filter chain and drives the first filter stage directly, for example the border overlay. Pattern mode is frame-synchronous, so changes never tear mid-frame.

---
 rtl/video_pkg.sv | 34 +++
 rtl/vid_pattern_gen_if.sv | 13 +
 rtl/vid_pattern_gen.sv | 177 +++++++++++++++++
 tb/tb_vid_pattern_gen.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared pixel, raster timing and sideband types for the video pipeline
package video_pkg;

  localparam int RGBW  = 4;
  localparam int SB_XW = 16;
  localparam int SB_YW = 16;

  typedef struct packed {
    logic [RGBW-1:0] r;
    logic [RGBW-1:0] g;
    logic [RGBW-1:0] b;
  } pixel_t;

  // Line/frame geometry in pixels/lines; POL 1 means the sync pulse is high
  typedef struct packed {
    int unsigned H_ACTIVE;
    int unsigned H_FRONT;
    int unsigned H_SYNC;
    int unsigned H_BACK;
    int unsigned V_ACTIVE;
    int unsigned V_FRONT;
    int unsigned V_SYNC;
    int unsigned V_BACK;
    logic        H_POL;
    logic        V_POL;
  } timing_t;

  localparam timing_t TIMING_VGA_640x480 = '{
    H_ACTIVE: 640, H_FRONT: 16, H_SYNC: 96, H_BACK: 48,
    V_ACTIVE: 480, V_FRONT: 10, V_SYNC: 2,  V_BACK: 33,
    H_POL: 1'b0, V_POL: 1'b0
  };

endpackage

// File: rtl/vid_pattern_gen_if.sv
// rtl/vid_pattern_gen_if.sv - pixel sideband bundle (de/sof/eol/x/y) between pipeline stages
interface vid_sideband_if;

  logic                      de;
  logic                      sof;
  logic                      eol;
  logic [video_pkg::SB_XW-1:0] x;
  logic [video_pkg::SB_YW-1:0] y;

  modport source (output de, sof, eol, x, y);
  modport sink   (input  de, sof, eol, x, y);

endinterface

// File: rtl/vid_pattern_gen.sv
// rtl/vid_pattern_gen.sv - free-running raster timing and frame-synchronous test pattern source
module vid_pattern_gen
  import video_pkg::*;
#(
  parameter timing_t T          = TIMING_VGA_640x480,
  parameter int      CHK_LOG2   = 5,
  parameter int      GRAD_SHIFT = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [1:0]     mode,
  input  pixel_t         solid,
  output pixel_t         px_out,
  vid_sideband_if.source sb_out,
  output logic           hsync,
  output logic           vsync
);

  localparam int unsigned H_TOTAL = T.H_ACTIVE + T.H_FRONT + T.H_SYNC + T.H_BACK;
  localparam int unsigned V_TOTAL = T.V_ACTIVE + T.V_FRONT + T.V_SYNC + T.V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  // Region edges kept 32 bits wide so an edge equal to the total cannot wrap
  localparam logic [31:0] H_LAST     = 32'(H_TOTAL - 1);
  localparam logic [31:0] V_LAST     = 32'(V_TOTAL - 1);
  localparam logic [31:0] H_ACT_END  = 32'(T.H_ACTIVE);
  localparam logic [31:0] V_ACT_END  = 32'(T.V_ACTIVE);
  localparam logic [31:0] H_SYNC_BEG = 32'(T.H_ACTIVE + T.H_FRONT);
  localparam logic [31:0] H_SYNC_END = 32'(T.H_ACTIVE + T.H_FRONT + T.H_SYNC);
  localparam logic [31:0] V_SYNC_BEG = 32'(T.V_ACTIVE + T.V_FRONT);
  localparam logic [31:0] V_SYNC_END = 32'(T.V_ACTIVE + T.V_FRONT + T.V_SYNC);

  // Colour bar left edges, folded to constants at elaboration
  localparam logic [31:0] BAR_B [8] = '{
    32'(0),
    32'((1 * T.H_ACTIVE) / 8), 32'((2 * T.H_ACTIVE) / 8),
    32'((3 * T.H_ACTIVE) / 8), 32'((4 * T.H_ACTIVE) / 8),
    32'((5 * T.H_ACTIVE) / 8), 32'((6 * T.H_ACTIVE) / 8),
    32'((7 * T.H_ACTIVE) / 8)
  };

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [31:0]   h_ext;
  logic [31:0]   v_ext;
  logic          h_last;
  logic          v_last;
  logic          at_origin;
  logic          active;
  logic          in_hsync;
  logic          in_vsync;

  logic [1:0]    mode_q;
  pixel_t        solid_q;
  logic [1:0]    mode_sel;
  pixel_t        solid_sel;
  logic [2:0]    bar_idx;
  logic [RGBW-1:0] grey;
  logic          chk_bit;
  pixel_t        px_d;

  logic          de_q;
  logic          sof_q;
  logic          eol_q;
  logic [SB_XW-1:0] x_q;
  logic [SB_YW-1:0] y_q;

  assign h_ext     = 32'(h_cnt);
  assign v_ext     = 32'(v_cnt);
  assign h_last    = (h_ext == H_LAST);
  assign v_last    = (v_ext == V_LAST);
  assign at_origin = (h_cnt == '0) && (v_cnt == '0);
  assign active    = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
  assign in_hsync  = (h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END);
  assign in_vsync  = (v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END);

  // Raster counters: advance while enabled, snap back to the origin when disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Capture pattern controls at the frame origin so one frame never mixes modes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= '0;
      solid_q <= '0;
    end else if (en && at_origin) begin
      mode_q  <= mode;
      solid_q <= solid;
    end
  end

  // Pattern decode; the origin pixel bypasses the latch so sof already shows the new mode
  always_comb begin
    mode_sel  = at_origin ? mode : mode_q;
    solid_sel = at_origin ? solid : solid_q;
    bar_idx   = '0;
    for (int k = 1; k < 8; k++) begin
      if (h_ext >= BAR_B[k]) bar_idx = k[2:0];
    end
    grey    = RGBW'(h_cnt >> GRAD_SHIFT);
    chk_bit = h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2];
    px_d    = '0;
    if (active) begin
      case (mode_sel)
        2'd0: begin
          px_d.r = {RGBW{~bar_idx[1]}};
          px_d.g = {RGBW{~bar_idx[2]}};
          px_d.b = {RGBW{~bar_idx[0]}};
        end
        2'd1: begin
          px_d.r = {RGBW{chk_bit}};
          px_d.g = {RGBW{chk_bit}};
          px_d.b = {RGBW{chk_bit}};
        end
        2'd2: begin
          px_d.r = grey;
          px_d.g = grey;
          px_d.b = grey;
        end
        default: px_d = solid_sel;
      endcase
    end
  end

  // Output registers: every output is decoded from the pre-edge counters, one cycle behind
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_out <= '0;
      de_q   <= 1'b0;
      sof_q  <= 1'b0;
      eol_q  <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      hsync  <= ~T.H_POL;
      vsync  <= ~T.V_POL;
    end else if (!en) begin
      px_out <= '0;
      de_q   <= 1'b0;
      sof_q  <= 1'b0;
      eol_q  <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      hsync  <= ~T.H_POL;
      vsync  <= ~T.V_POL;
    end else begin
      px_out <= px_d;
      de_q   <= active;
      sof_q  <= active && at_origin;
      eol_q  <= active && (h_ext == H_ACT_END - 32'd1);
      x_q    <= active ? SB_XW'(h_cnt) : '0;
      y_q    <= active ? SB_YW'(v_cnt) : '0;
      hsync  <= in_hsync ? T.H_POL : ~T.H_POL;
      vsync  <= in_vsync ? T.V_POL : ~T.V_POL;
    end
  end

  assign sb_out.de  = de_q;
  assign sb_out.sof = sof_q;
  assign sb_out.eol = eol_q;
  assign sb_out.x   = x_q;
  assign sb_out.y   = y_q;

endmodule

// File: tb/tb_vid_pattern_gen.sv
// tb/tb_vid_pattern_gen.sv - self-checking bench for vid_pattern_gen on a reduced raster
module tb_vid_pattern_gen;
  import video_pkg::*;

  // Small raster so many frames fit in a short run: 96 x 47 = 4512 cycles per frame
  localparam timing_t TB_T = '{
    H_ACTIVE: 80, H_FRONT: 4, H_SYNC: 6, H_BACK: 6,
    V_ACTIVE: 40, V_FRONT: 3, V_SYNC: 2, V_BACK: 2,
    H_POL: 1'b0, V_POL: 1'b0
  };
  localparam int HA = 80, HT = 96, VA = 40, VT = 47, FRAME = HT * VT;
  localparam int HS_B = 84, HS_E = 90, VS_B = 43, VS_E = 45;

  localparam logic [11:0] BAR_COL [8] = '{
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000
  };

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  pixel_t     solid;
  pixel_t     px_out;
  logic       hsync;
  logic       vsync;
  logic [11:0] px_v;

  vid_sideband_if sb ();

  vid_pattern_gen #(.T(TB_T), .CHK_LOG2(5), .GRAD_SHIFT(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .mode   (mode),
    .solid  (solid),
    .px_out (px_out),
    .sb_out (sb),
    .hsync  (hsync),
    .vsync  (vsync)
  );

  assign px_v = px_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [11:0] model_px(input int h, input int v,
                                           input logic [1:0] md, input logic [11:0] sl);
    logic [3:0] g;
    if (h >= HA || v >= VA) return 12'h000;
    case (md)
      2'd0:    return BAR_COL[h * 8 / HA];
      2'd1:    return ((((h / 32) + (v / 32)) % 2) == 1) ? 12'hFFF : 12'h000;
      2'd2: begin
        g = 4'((h / 4) % 16);
        return {g, g, g};
      end
      default: return sl;
    endcase
  endfunction

  // Behavioural model: position is cycles since enable, mode is sampled at each frame start
  int          t = 0;
  logic [1:0]  m_mode = 2'd0;
  logic [11:0] m_solid = 12'h000;
  bit          model_on = 1'b0;

  always @(posedge clk) begin : model_proc
    int h, v;
    logic act;
    logic [11:0] e_px;
    int e_x, e_y;
    logic e_de, e_sof, e_eol, e_hs, e_vs;
    if (!rst_n || !en) begin
      if (!rst_n) begin
        m_mode  = 2'd0;
        m_solid = 12'h000;
      end
      t = 0;
      e_px = 12'h000; e_x = 0; e_y = 0;
      e_de = 1'b0; e_sof = 1'b0; e_eol = 1'b0; e_hs = 1'b1; e_vs = 1'b1;
    end else begin
      if (t % FRAME == 0) begin
        m_mode  = mode;
        m_solid = solid;
      end
      h = t % HT;
      v = (t / HT) % VT;
      act   = (h < HA) && (v < VA);
      e_px  = model_px(h, v, m_mode, m_solid);
      e_de  = act;
      e_sof = act && h == 0 && v == 0;
      e_eol = act && h == HA - 1;
      e_x   = act ? h : 0;
      e_y   = act ? v : 0;
      e_hs  = !(h >= HS_B && h < HS_E);
      e_vs  = !(v >= VS_B && v < VS_E);
      t++;
    end
    #1;
    if (model_on) begin
      chk("m_px", int'(px_v), int'(e_px));
      chk("m_de", int'(sb.de), int'(e_de));
      chk("m_sof", int'(sb.sof), int'(e_sof));
      chk("m_eol", int'(sb.eol), int'(e_eol));
      chk("m_x", int'(sb.x), e_x);
      chk("m_y", int'(sb.y), e_y);
      chk("m_hsync", int'(hsync), int'(e_hs));
      chk("m_vsync", int'(vsync), int'(e_vs));
    end
  end

  // Wait (bounded) until the output shows pixel (xx,yy), then pin its colour
  task automatic check_at(input string name, input int xx, input int yy, input logic [11:0] req);
    int n;
    n = 0;
    while (!(sb.de === 1'b1 && int'(sb.x) == xx && int'(sb.y) == yy) && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_reach"}, (n < 3 * FRAME) ? 1 : 0, 1);
    chk(name, int'(px_v), int'(req));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_px"}, int'(px_v), 0);
    chk({tag, "_de"}, int'(sb.de), 0);
    chk({tag, "_sof"}, int'(sb.sof), 0);
    chk({tag, "_eol"}, int'(sb.eol), 0);
    chk({tag, "_x"}, int'(sb.x), 0);
    chk({tag, "_y"}, int'(sb.y), 0);
    chk({tag, "_hsync"}, int'(hsync), 1);
    chk({tag, "_vsync"}, int'(vsync), 1);
  endtask

  // Count one sof-to-sof frame and pin its line/frame timing with literal numbers
  task automatic measure_frame(input string tag);
    int cnt, de_cnt, hs_low, vs_low, vs_first, de_last, good_dly, good_run;
    int fall_at, eol_at, n;
    logic prev_hs, eol_seen;
    n = 0;
    while (sb.sof !== 1'b1 && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_sof_reach"}, int'(sb.sof === 1'b1), 1);
    cnt = 0; de_cnt = 0; hs_low = 0; vs_low = 0; vs_first = -1; de_last = -1;
    good_dly = 0; good_run = 0; fall_at = 0; eol_at = 0;
    prev_hs = 1'b1; eol_seen = 1'b0;
    do begin
      if (sb.de) begin
        de_cnt++;
        de_last = cnt;
      end
      if (!vsync) begin
        vs_low++;
        if (vs_first < 0) vs_first = cnt;
      end
      if (!hsync) hs_low++;
      if (!hsync && prev_hs) begin
        fall_at = cnt;
        if (eol_seen && (cnt - eol_at) == 5) good_dly++;
        eol_seen = 1'b0;
      end
      if (hsync && !prev_hs && (cnt - fall_at) == 6) good_run++;
      if (sb.eol) begin
        eol_seen = 1'b1;
        eol_at   = cnt;
      end
      prev_hs = hsync;
      cnt++;
      @(negedge clk);
    end while (sb.sof !== 1'b1 && cnt < FRAME + 50);
    chk({tag, "_period"}, cnt, 4512);
    chk({tag, "_de_cycles"}, de_cnt, 3200);
    chk({tag, "_de_last"}, de_last, 3823);
    chk({tag, "_hs_low"}, hs_low, 282);
    chk({tag, "_hs_width_ok"}, good_run, 47);
    chk({tag, "_hs_after_eol_ok"}, good_dly, 40);
    chk({tag, "_vs_low"}, vs_low, 192);
    chk({tag, "_vs_start"}, vs_first, 4128);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    mode  = 2'd0;
    solid = '0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    model_on = 1'b1;

    rst_n = 1'b1;
    en    = 1'b1;
    @(negedge clk);
    chk("first_sof", int'(sb.sof), 1);
    chk("first_de", int'(sb.de), 1);
    chk("first_x", int'(sb.x), 0);
    chk("first_y", int'(sb.y), 0);
    chk("first_px", int'(px_v), 12'hFFF);

    check_at("bar_x9_white", 9, 0, 12'hFFF);
    check_at("bar_x10_yellow", 10, 0, 12'hFF0);
    check_at("bar_x20_cyan", 20, 0, 12'h0FF);
    check_at("bar_x75_black", 75, 5, 12'h000);
    check_at("bar_x79_black", 79, 39, 12'h000);

    measure_frame("f1");

    mode = 2'd1;
    check_at("bars_hold", 20, 2, 12'h0FF);
    check_at("chk_0_0", 0, 0, 12'h000);
    check_at("chk_32_0", 32, 0, 12'hFFF);
    check_at("chk_32_32", 32, 32, 12'h000);

    mode = 2'd2;
    check_at("grad_x0", 0, 0, 12'h000);
    check_at("grad_x3", 3, 1, 12'h000);
    check_at("grad_x4", 4, 1, 12'h111);
    check_at("grad_x63", 63, 1, 12'hFFF);
    check_at("grad_x64_wrap", 64, 1, 12'h000);

    mode = 2'd0;
    check_at("bars_back", 0, 0, 12'hFFF);
    check_at("bars_y10", 0, 10, 12'hFFF);
    mode  = 2'd3;
    solid = '{r: 4'h5, g: 4'hA, b: 4'h3};
    check_at("bars_rest", 10, 20, 12'hFF0);
    check_at("solid_sof", 0, 0, 12'h5A3);
    check_at("solid_end", 79, 39, 12'h5A3);

    for (int i = 0; i < FRAME + 100; i++) begin
      @(negedge clk);
      mode  = 2'($urandom_range(0, 3));
      solid = pixel_t'(12'($urandom));
    end
    mode  = 2'd0;
    solid = '0;
    check_at("bars_resume", 0, 0, 12'hFFF);

    check_at("drop_pos", 30, 20, 12'h0F0);
    en = 1'b0;
    @(negedge clk);
    chk_idle("en_low");
    repeat (9) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    chk("reen_sof", int'(sb.sof), 1);
    chk("reen_de", int'(sb.de), 1);
    chk("reen_x", int'(sb.x), 0);
    chk("reen_y", int'(sb.y), 0);
    chk("reen_px", int'(px_v), 12'hFFF);
    measure_frame("reen");

    check_at("pre_reset", 40, 15, 12'hF0F);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_sof", int'(sb.sof), 1);
    chk("post_rst_x", int'(sb.x), 0);
    chk("post_rst_px", int'(px_v), 12'hFFF);

    repeat (20) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
